// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache miss-refill sequencer: FSM encoding and
// the back-end byte address builder.
package cache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VICTIM,
    ST_WB_RD,
    ST_WB_CAP,
    ST_WB_WR,
    ST_FILL,
    ST_COMMIT,
    ST_DONE
  } refill_state_e;

  // Computed at 64 bits so it serves any field widths; callers truncate to ADDR_W.
  function automatic logic [63:0] line_byte_addr(
    input logic [63:0] tag,
    input logic [63:0] index,
    input logic [63:0] word,
    input int unsigned index_w,
    input int unsigned word_w
  );
    return (tag << (index_w + word_w + 2)) | (index << (word_w + 2)) | (word << 2);
  endfunction

endpackage

// File: rtl/cache_refill_addr_gen.sv
// Word counter for the line being moved, plus back-end byte address generation
// for either the victim tag (write-back) or the missing tag (refill).
module cache_refill_addr_gen
  import cache_refill_ctrl_pkg::*;
#(
  parameter int LINE_OFF_W = 7,
  parameter int WORD_OFF_W = 3,
  parameter int TAG_W      = 20,
  parameter int ADDR_W     = TAG_W + LINE_OFF_W + WORD_OFF_W + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cnt_clr,
  input  logic                  cnt_inc,
  input  logic                  sel_victim,
  input  logic [TAG_W-1:0]      miss_tag,
  input  logic [TAG_W-1:0]      victim_tag,
  input  logic [LINE_OFF_W-1:0] index,
  output logic [WORD_OFF_W-1:0] cnt,
  output logic                  cnt_last,
  output logic [ADDR_W-1:0]     addr
);

  logic [WORD_OFF_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]      tag_sel;

  assign cnt_last = &cnt_q;
  assign cnt      = cnt_q;

  // The counter saturates at the last word; the FSM clears it between phases.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && !cnt_last) begin
      cnt_d = cnt_q + WORD_OFF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tag_sel = sel_victim ? victim_tag : miss_tag;
  assign addr    = ADDR_W'(line_byte_addr(64'(tag_sel), 64'(index), 64'(cnt_q),
                                          LINE_OFF_W, WORD_OFF_W));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling sequencer: picks a victim way, writes it back when dirty,
// refills the line from the back-end, then commits the tag and updates policy.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int N_WAYS     = 8,
  parameter int NWAY_W     = $clog2(N_WAYS),
  parameter int LINE_OFF_W = 7,
  parameter int WORD_OFF_W = 3,
  parameter int TAG_W      = 20,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = TAG_W + LINE_OFF_W + WORD_OFF_W + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  input  logic [TAG_W-1:0]      miss_tag,
  input  logic [LINE_OFF_W-1:0] miss_index,
  output logic                  busy,
  output logic                  done,
  output logic [LINE_OFF_W-1:0] rp_line_addr,
  input  logic [NWAY_W-1:0]     rp_way_select_bin,
  output logic                  rp_write_en,
  output logic [N_WAYS-1:0]     rp_way_hit,
  input  logic [TAG_W-1:0]      vic_tag,
  input  logic                  vic_valid,
  input  logic                  vic_dirty,
  output logic                  dmem_en,
  output logic                  dmem_we,
  output logic [NWAY_W-1:0]     dmem_way,
  output logic [LINE_OFF_W-1:0] dmem_index,
  output logic [WORD_OFF_W-1:0] dmem_word,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  tag_we,
  output logic [NWAY_W-1:0]     tag_way,
  output logic [LINE_OFF_W-1:0] tag_index,
  output logic [TAG_W-1:0]      tag_wdata,
  output logic                  mem_valid,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  refill_state_e         state_q, state_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [TAG_W-1:0]      vtag_q, vtag_d;
  logic [LINE_OFF_W-1:0] index_q, index_d;
  logic [NWAY_W-1:0]     way_q, way_d;
  logic [DATA_W-1:0]     wb_buf_q, wb_buf_d;
  logic                  mem_valid_q, mem_valid_d;

  logic                  cnt_clr, cnt_inc, cnt_last;
  logic [WORD_OFF_W-1:0] cnt;
  logic                  mem_hs;

  cache_refill_addr_gen #(
    .LINE_OFF_W (LINE_OFF_W),
    .WORD_OFF_W (WORD_OFF_W),
    .TAG_W      (TAG_W),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .cnt_clr    (cnt_clr),
    .cnt_inc    (cnt_inc),
    .sel_victim (state_q == ST_WB_WR),
    .miss_tag   (tag_q),
    .victim_tag (vtag_q),
    .index      (index_q),
    .cnt        (cnt),
    .cnt_last   (cnt_last),
    .addr       (mem_addr)
  );

  // mem_valid is registered, so every transfer is preceded by a low cycle,
  // which gives the mandatory gap between back-end transactions.
  assign mem_hs       = mem_valid_q && mem_ready;
  assign mem_valid    = mem_valid_q;
  assign mem_wdata    = wb_buf_q;
  assign mem_wstrb    = (state_q == ST_WB_WR) ? '1 : '0;
  assign busy         = (state_q != ST_IDLE);
  assign rp_line_addr = busy ? index_q : miss_index;
  assign dmem_way     = way_q;
  assign dmem_index   = index_q;
  assign dmem_word    = cnt;
  assign tag_way      = way_q;
  assign tag_index    = index_q;
  assign tag_wdata    = tag_q;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    vtag_d      = vtag_q;
    index_d     = index_q;
    way_d       = way_q;
    wb_buf_d    = wb_buf_q;
    mem_valid_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    dmem_en     = 1'b0;
    dmem_we     = 1'b0;
    dmem_wdata  = '0;
    tag_we      = 1'b0;
    rp_write_en = 1'b0;
    rp_way_hit  = '0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          tag_d   = miss_tag;
          index_d = miss_index;
          state_d = ST_VICTIM;
        end
      end
      ST_VICTIM: begin
        way_d   = rp_way_select_bin;
        vtag_d  = vic_tag;
        cnt_clr = 1'b1;
        state_d = (vic_valid && vic_dirty) ? ST_WB_RD : ST_FILL;
      end
      ST_WB_RD: begin
        dmem_en = 1'b1;
        state_d = ST_WB_CAP;
      end
      ST_WB_CAP: begin
        wb_buf_d = dmem_rdata;
        state_d  = ST_WB_WR;
      end
      ST_WB_WR: begin
        if (mem_hs) begin
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = ST_FILL;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_WB_RD;
          end
        end else begin
          mem_valid_d = 1'b1;
        end
      end
      ST_FILL: begin
        if (mem_hs) begin
          dmem_en    = 1'b1;
          dmem_we    = 1'b1;
          dmem_wdata = mem_rdata;
          if (cnt_last) begin
            state_d = ST_COMMIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end else begin
          mem_valid_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        tag_we      = 1'b1;
        rp_write_en = 1'b1;
        rp_way_hit  = N_WAYS'(1) << way_q;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      vtag_q      <= '0;
      index_q     <= '0;
      way_q       <= '0;
      wb_buf_q    <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      vtag_q      <= vtag_d;
      index_q     <= index_d;
      way_q       <= way_d;
      wb_buf_q    <= wb_buf_d;
      mem_valid_q <= mem_valid_d;
    end
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling sequencer for the set-associative cache.
- On a front-end miss it consults the replacement policy for a victim way, writes the victim back if it is valid and dirty, then refills the line word by word from the back-end memory.
- It then commits tag/valid/dirty and pulses a policy update so the refilled way becomes most recently used.
- Sits between the cache front-end, the tag/data memories, the replacement_policy instance and the back-end memory port.

Parameters:
- N_WAYS, 8, number of ways (power of 2, >=2)
- NWAY_W, $clog2(N_WAYS), way index width
- LINE_OFF_W, 7, set index width
- WORD_OFF_W, 3, log2 words per line
- TAG_W, 20, tag width
- DATA_W, 32, word width (byte address = {tag, index, word, 2'b00})
- ADDR_W, TAG_W+LINE_OFF_W+WORD_OFF_W+2, back-end byte address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- miss_valid  in  1  front-end miss request; held by the front-end until done
- miss_tag  in  TAG_W  missing tag
- miss_index  in  LINE_OFF_W  missing set
- busy  out  1  controller not idle
- done  out  1  one-cycle pulse when the line is committed
- rp_line_addr  out  LINE_OFF_W  set index to replacement_policy (latched index while busy, else miss_index)
- rp_way_select_bin  in  NWAY_W  victim way from replacement_policy
- rp_write_en  out  1  policy update strobe
- rp_way_hit  out  N_WAYS  one-hot way for the policy update
- vic_tag  in  TAG_W  tag of way rp_way_select_bin at rp_line_addr (combinational)
- vic_valid  in  1  victim valid bit
- vic_dirty  in  1  victim dirty bit
- dmem_en  out  1  data memory access enable
- dmem_we  out  1  data memory write
- dmem_way  out  NWAY_W  way for the access
- dmem_index  out  LINE_OFF_W  set for the access
- dmem_word  out  WORD_OFF_W  word offset for the access
- dmem_wdata  out  DATA_W  refill data
- dmem_rdata  in  DATA_W  read data, 1-cycle latency
- tag_we  out  1  tag/valid/dirty write strobe
- tag_way  out  NWAY_W  way for the tag write
- tag_index  out  LINE_OFF_W  set for the tag write
- tag_wdata  out  TAG_W  new tag; valid written 1, dirty written 0
- mem_valid  out  1  back-end request
- mem_addr  out  ADDR_W  back-end byte address
- mem_wdata  out  DATA_W  write-back data
- mem_wstrb  out  DATA_W/8  all ones for write-back, zero for reads
- mem_rdata  in  DATA_W  back-end read data, valid with mem_ready
- mem_ready  in  1  back-end accept/complete; may be combinational on mem_valid

Behaviour:
- Reset (synchronous): FSM to IDLE, word counter 0. busy, done, rp_write_en, dmem_en, dmem_we, tag_we, mem_valid = 0; mem_wstrb = 0; all address/data registers 0.
- Reset mid-operation: the controller aborts immediately and mem_valid drops in the cycle after reset. A partial refill leaves the line's valid bit unchanged (commit never happened).
- IDLE: busy=0. If miss_valid is high, latch tag/index and go to VICTIM.
- VICTIM (1 cycle): latch way=rp_way_select_bin, vtag=vic_tag, wb=vic_valid&vic_dirty, cnt=0.
  - If wb, go to WB_RD; otherwise go to FILL.
- WB_RD: dmem_en=1, we=0, way/index/word=cnt. Go to WB_CAP.
- WB_CAP: capture dmem_rdata into wb_buf. Go to WB_WR.
- WB_WR: mem_valid=1, mem_addr={vtag,index,cnt,2'b00}, mem_wdata=wb_buf, mem_wstrb all ones. Hold all of these until mem_ready.
  - On mem_ready: if cnt is the last word, go to FILL with cnt=0; otherwise cnt+1 and return to WB_RD.
- FILL: mem_valid=1, mem_addr={tag,index,cnt,2'b00}, mem_wstrb=0.
  - On mem_ready, in the same cycle: dmem_en=1, dmem_we=1, dmem_wdata=mem_rdata, dmem_word=cnt.
  - Then: if last word go to COMMIT; else cnt+1 and stay in FILL.
- Back-end handshake: mem_valid deasserts for at least one cycle between transactions. Address and data stay stable while mem_valid=1 and mem_ready=0.
- COMMIT (1 cycle): tag_we=1 (tag, valid=1, dirty=0 at way/index); rp_write_en=1, rp_way_hit=1<<way. Go to DONE.
- DONE (1 cycle): done=1. Go to IDLE. The front-end drops miss_valid on done; miss_valid seen high in the IDLE cycle after DONE is a new miss.
- busy=1 in every state except IDLE. miss_valid changes while busy are ignored.
- Counter: cnt is WORD_OFF_W wide. "Last" means cnt == all ones; no wrap beyond it.
- Latency with a zero-wait back-end (mem_ready same cycle): clean miss = 2^WORD_OFF_W*2 + 4 cycles from miss_valid to done; dirty miss adds 4 cycles per word.
- rp_way_hit=0 and rp_write_en=0 outside COMMIT, so policy state never changes on a miss in progress.

Decomposition:
- Shared package: FSM state encoding (IDLE, VICTIM, WB_RD, WB_CAP, WB_WR, FILL, COMMIT, DONE) and a helper for the address concatenation.
- One natural sub-module: cache_refill_addr_gen, holding the word counter and the back-end/data-memory address generation with the last-word flag.

Test Plan:
- Clean miss, tag 0x12345, index 5, victim way 3 invalid, mem_ready tied 1 -> 8 reads at 0x12345_0A0..0BC with dmem writes to way 3 words 0..7; then tag_we with tag 0x12345, rp_way_hit=0x08, done exactly 20 cycles after miss_valid.
- Dirty victim (vtag 0x00ABC, index 5, way 6) -> 8 writes at 0x00ABC_0A0.. with mem_wstrb=0xF and data from dmem words 0..7 in order; refill follows; rp_way_hit=0x40.
- Back-end wait states: mem_ready delayed 3 cycles per word -> mem_addr/mem_wdata stable during waits, mem_valid low for at least one cycle between words, data is correct.
- Reset asserted during FILL word 4 -> next cycle busy=0 and mem_valid=0, no tag_we or rp_write_en, then a new miss completes normally.
- Back-to-back misses (miss_valid held, then re-asserted the cycle after done) -> two independent sequences, each with exactly one done pulse and one rp_write_en.
- miss_tag/miss_index changed while busy -> ignored; refill and commit use the values latched at IDLE.
